// File: rtl/axis_tx_frame_monitor.sv
// AXI-Stream TX sink: programmable backpressure, frame/line tracking,
// per-frame statistics, checksum and sticky protocol-error flags.
//
// Ports:
//   aclk, aclk_reset_n        clock, async active-low reset
//   s_axis_t*                 AXIS slave (tuser: 0 SOF, 1 EOF, 2 SOL, 3 EOL)
//   bp_enable, bp_pattern     backpressure control (pattern bit per phase)
//   clr_stats                 sync clear of stats, errors and FSM
//   frame_done                one-cycle pulse per completed frame
//   frame_count               completed frames (wrapping)
//   line_beats, frame_lines   geometry of last completed frame
//   frame_checksum            32-bit word sum of last completed frame
//   err_flags                 sticky: 0 stab, 1 seq, 2 len, 3 tlast/EOL
module axis_tx_frame_monitor #(
    parameter int T_DATA_WIDTH = 64,
    parameter int T_USER_WIDTH = 4
) (
    input  logic                    aclk,
    input  logic                    aclk_reset_n,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [T_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [T_USER_WIDTH-1:0] s_axis_tuser,
    input  logic                    s_axis_tlast,
    input  logic                    bp_enable,
    input  logic [15:0]             bp_pattern,
    input  logic                    clr_stats,
    output logic                    frame_done,
    output logic [31:0]             frame_count,
    output logic [15:0]             line_beats,
    output logic [15:0]             frame_lines,
    output logic [31:0]             frame_checksum,
    output logic [3:0]              err_flags
);

    localparam int NW = T_DATA_WIDTH / 32;

    localparam logic [1:0] WAIT_SOF = 2'd0;
    localparam logic [1:0] IN_LINE  = 2'd1;
    localparam logic [1:0] WAIT_SOL = 2'd2;

    logic [3:0]              ph;
    logic [1:0]              state;
    logic [1:0]              state_nx;
    logic [15:0]             beats;
    logic [15:0]             lines;
    logic [15:0]             ref_beats;
    logic [31:0]             sum;

    logic                    stall_q;
    logic [T_DATA_WIDTH-1:0] data_q;
    logic [T_USER_WIDTH-1:0] user_q;
    logic                    last_q;

    logic        sof, eof, sol, eol;
    logic        acc;
    logic        start, cont, newl, live;
    logic [31:0] bsum;
    logic [31:0] sum_now;
    logic [15:0] beats_now;
    logic [15:0] lines_base;
    logic [15:0] lines_now;
    logic        first_line;
    logic        line_end;
    logic        frame_end;
    logic        seq_err, len_err, last_err, stab_err;

    assign sof = s_axis_tuser[0];
    assign eof = s_axis_tuser[1];
    assign sol = s_axis_tuser[2];
    assign eol = s_axis_tuser[3];
    assign acc = s_axis_tvalid & s_axis_tready;

    always_comb begin
        bsum = '0;
        for (int i = 0; i < NW; i++) begin
            bsum = bsum + s_axis_tdata[i*32 +: 32];
        end
    end

    always_comb begin
        start      = acc & sof;
        cont       = acc & ~sof & (state == IN_LINE);
        newl       = acc & ~sof & (state == WAIT_SOL);
        live       = start | cont | newl;

        // An SOF beat always opens a fresh frame, whatever the state.
        lines_base = start ? 16'd0 : lines;
        sum_now    = start ? bsum : sum + bsum;

        if (start | newl)
            beats_now = 16'd1;
        else if (beats == 16'hFFFF)
            beats_now = 16'hFFFF;
        else
            beats_now = beats + 16'd1;

        lines_now  = (lines_base == 16'hFFFF) ?
                     16'hFFFF : lines_base + 16'd1;
        first_line = (lines_base == 16'd0);
        line_end   = live & s_axis_tlast;
        frame_end  = line_end & eof;

        seq_err  = (acc & ~sof & (state == WAIT_SOF)) |
                   (acc &  sof & (state != WAIT_SOF)) |
                   (newl & ~sol);
        len_err  = line_end & ~first_line & (beats_now != ref_beats);
        last_err = live & ((s_axis_tlast & ~eol) |
                           (~s_axis_tlast & (eol | eof)));
        // A stalled beat must be held unchanged until taken.
        stab_err = stall_q & (~s_axis_tvalid |
                              (s_axis_tdata != data_q) |
                              (s_axis_tuser != user_q) |
                              (s_axis_tlast != last_q));

        if (frame_end)
            state_nx = WAIT_SOF;
        else if (line_end)
            state_nx = WAIT_SOL;
        else if (live)
            state_nx = IN_LINE;
        else
            state_nx = state;
    end

    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            ph            <= '0;
            s_axis_tready <= 1'b0;
            stall_q       <= 1'b0;
            data_q        <= '0;
            user_q        <= '0;
            last_q        <= 1'b0;
        end else begin
            ph            <= ph + 4'd1;
            s_axis_tready <= ~bp_enable | bp_pattern[ph];
            stall_q       <= s_axis_tvalid & ~s_axis_tready;
            data_q        <= s_axis_tdata;
            user_q        <= s_axis_tuser;
            last_q        <= s_axis_tlast;
        end
    end

    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            state          <= WAIT_SOF;
            beats          <= '0;
            lines          <= '0;
            ref_beats      <= '0;
            sum            <= '0;
            frame_done     <= 1'b0;
            frame_count    <= '0;
            line_beats     <= '0;
            frame_lines    <= '0;
            frame_checksum <= '0;
            err_flags      <= '0;
        end else if (clr_stats) begin
            state          <= WAIT_SOF;
            beats          <= '0;
            lines          <= '0;
            ref_beats      <= '0;
            sum            <= '0;
            frame_done     <= 1'b0;
            frame_count    <= '0;
            line_beats     <= '0;
            frame_lines    <= '0;
            frame_checksum <= '0;
            err_flags      <= '0;
        end else begin
            frame_done <= 1'b0;
            state      <= state_nx;
            err_flags  <= err_flags |
                          {last_err, len_err, seq_err, stab_err};
            if (live) begin
                beats <= beats_now;
                sum   <= sum_now;
                lines <= line_end ? lines_now : lines_base;
                if (line_end & first_line)
                    ref_beats <= beats_now;
            end
            if (frame_end) begin
                frame_done     <= 1'b1;
                frame_count    <= frame_count + 32'd1;
                line_beats     <= first_line ? beats_now : ref_beats;
                frame_lines    <= lines_now;
                frame_checksum <= sum_now;
            end
        end
    end

endmodule

// File: tb/tb_axis_tx_frame_monitor.sv
// Bench for axis_tx_frame_monitor: random-data frames against a
// frame-level reference model, scoreboard checked on frame_done.
module tb_axis_tx_frame_monitor;

    localparam int DW = 64;
    localparam int UW = 4;

    logic          tb_CLK = 1'b0;
    logic          rst_n;
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic [UW-1:0] tuser;
    logic          tlast;
    logic          bp_enable;
    logic [15:0]   bp_pattern;
    logic          clr_stats;
    logic          frame_done;
    logic [31:0]   frame_count;
    logic [15:0]   line_beats;
    logic [15:0]   frame_lines;
    logic [31:0]   frame_checksum;
    logic [3:0]    err_flags;

    always #5 tb_CLK = ~tb_CLK;

    axis_tx_frame_monitor #(
        .T_DATA_WIDTH(DW),
        .T_USER_WIDTH(UW)
    ) dut (
        .aclk          (tb_CLK),
        .aclk_reset_n  (rst_n),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .s_axis_tdata  (tdata),
        .s_axis_tuser  (tuser),
        .s_axis_tlast  (tlast),
        .bp_enable     (bp_enable),
        .bp_pattern    (bp_pattern),
        .clr_stats     (clr_stats),
        .frame_done    (frame_done),
        .frame_count   (frame_count),
        .line_beats    (line_beats),
        .frame_lines   (frame_lines),
        .frame_checksum(frame_checksum),
        .err_flags     (err_flags)
    );

    typedef struct {
        logic [31:0] count;
        logic [15:0] beats;
        logic [15:0] lines;
        logic [31:0] csum;
    } exp_t;

    exp_t        sb[$];
    int          line_len[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_count = 0;
    logic [3:0]  exp_err = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge tb_CLK);
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send_beat(input logic [DW-1:0] d, input logic [3:0] u,
                             input logic l, input logic clr);
        int w;
        w = 0;
        tvalid = 1'b1;
        tdata = d;
        tuser = u;
        tlast = l;
        clr_stats = clr;
        while (tready !== 1'b1 && w < 64) begin
            @(negedge tb_CLK);
            w++;
        end
        if (w >= 64) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: tready 0 for %0d cycles, required 1",
                     w);
        end
        @(negedge tb_CLK);
        tvalid = 1'b0;
        clr_stats = 1'b0;
    endtask

    task automatic do_clr();
        clr_stats = 1'b1;
        @(negedge tb_CLK);
        clr_stats = 1'b0;
        exp_count = 0;
        exp_err = 0;
    endtask

    // Frame geometry comes from line_len; the model sums every 32-bit
    // word and predicts the stats reported at frame_done.
    task automatic send_frame(input bit clr_last);
        logic [DW-1:0] dq[$];
        logic [31:0]   s;
        int            nl;
        int            k;
        exp_t          e;
        logic          sof, eof, sol, eol;
        s = 0;
        nl = line_len.size();
        for (int li = 0; li < nl; li++) begin
            if (line_len[li] != line_len[0])
                exp_err = exp_err | 4'b0100;
            for (int bi = 0; bi < line_len[li]; bi++) begin
                logic [DW-1:0] d;
                d = {$urandom, $urandom};
                dq.push_back(d);
                s = s + d[31:0] + d[63:32];
            end
        end
        if (!clr_last) begin
            exp_count = exp_count + 1;
            e.count = exp_count;
            e.beats = 16'(line_len[0]);
            e.lines = 16'(nl);
            e.csum = s;
            sb.push_back(e);
        end
        k = 0;
        for (int li = 0; li < nl; li++) begin
            for (int bi = 0; bi < line_len[li]; bi++) begin
                sof = (li == 0) && (bi == 0);
                eof = (li == nl - 1) && (bi == line_len[li] - 1);
                sol = (bi == 0);
                eol = (bi == line_len[li] - 1);
                send_beat(dq[k], {eol, sol, eof, sof}, eol, clr_last && eof);
                k++;
            end
        end
        if (clr_last) begin
            exp_count = 0;
            exp_err = 0;
        end
    endtask

    always @(negedge tb_CLK) begin
        if (rst_n === 1'b1 && frame_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_frame_done: got 1, required 0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("frame_count", frame_count, e.count);
                chk("line_beats", line_beats, e.beats);
                chk("frame_lines", frame_lines, e.lines);
                chk("frame_checksum", frame_checksum, e.csum);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        rst_n = 1'b0;
        tvalid = 1'b0;
        tdata = '0;
        tuser = '0;
        tlast = 1'b0;
        bp_enable = 1'b0;
        bp_pattern = '0;
        clr_stats = 1'b0;
        idle(3);
        chk("rst_tready", tready, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_line_beats", line_beats, 0);
        chk("rst_frame_lines", frame_lines, 0);
        chk("rst_checksum", frame_checksum, 0);
        chk("rst_err", err_flags, 0);
        rst_n = 1'b1;
        idle(2);

        line_len = '{8, 8, 8, 8};
        repeat (3) send_frame(0);
        idle(3);
        chk("s1_count", frame_count, exp_count);
        chk("s1_err", err_flags, exp_err);

        bp_enable = 1'b1;
        bp_pattern = 16'h5555;
        idle(2);
        for (int i = 0; i < 16; i++) begin
            v[i] = tready;
            @(negedge tb_CLK);
        end
        chk("s2_toggle", (v == 16'h5555) || (v == 16'hAAAA), 1);
        repeat (3) send_frame(0);
        bp_pattern = 16'($urandom) | 16'h0001;
        begin
            int len;
            len = $urandom_range(1, 12);
            line_len = '{len, len, len};
        end
        send_frame(0);
        idle(3);
        chk("s2_count", frame_count, exp_count);
        chk("s2_err", err_flags, exp_err);

        bp_enable = 1'b0;
        line_len = '{8, 8, 7, 8};
        send_frame(0);
        idle(3);
        chk("s3_err", err_flags, exp_err);
        chk("s3_count", frame_count, exp_count);
        do_clr();
        idle(1);
        chk("clr_count", frame_count, 0);
        chk("clr_err", err_flags, 0);

        send_beat({$urandom, $urandom}, 4'b0000, 1'b0, 1'b0);
        exp_err = exp_err | 4'b0010;
        bp_enable = 1'b1;
        bp_pattern = 16'h0000;
        idle(2);
        tvalid = 1'b1;
        tdata = 64'h1111_2222_3333_4444;
        tuser = 4'b0101;
        tlast = 1'b0;
        @(negedge tb_CLK);
        tdata = 64'h5555_6666_7777_8888;
        @(negedge tb_CLK);
        tvalid = 1'b0;
        bp_enable = 1'b0;
        exp_err = exp_err | 4'b0001;
        idle(3);
        chk("s4_err", err_flags, exp_err);
        chk("s4_count", frame_count, exp_count);
        line_len = '{8, 8, 8, 8};
        send_frame(0);
        idle(3);
        chk("s4_count_after", frame_count, exp_count);
        chk("s4_err_after", err_flags, exp_err);
        do_clr();

        line_len = '{1, 1};
        send_frame(0);
        idle(3);
        chk("s5_err", err_flags, exp_err);

        line_len = '{4, 4};
        send_frame(1);
        idle(3);
        chk("s6_count", frame_count, 0);
        chk("s6_err", err_flags, 0);
        send_beat({$urandom, $urandom}, 4'b0100, 1'b0, 1'b0);
        idle(2);
        chk("s6_wait_sof", err_flags, 4'b0010);
        do_clr();
        line_len = '{8, 8, 8, 8};
        send_frame(0);

        bp_enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            int nl;
            int len;
            bp_pattern = 16'($urandom) | 16'h0100;
            nl = $urandom_range(1, 5);
            len = $urandom_range(1, 10);
            line_len = {};
            for (int i = 0; i < nl; i++) line_len.push_back(len);
            send_frame(0);
        end
        idle(4);
        chk("final_count", frame_count, exp_count);
        chk("final_err", err_flags, exp_err);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
